inst_fetch_unit: RTL and testbench

- Instruction fetch stage directly upstream of the S-Machine CPU core.
- Reads the core's 8-bit PC and fetches the 16-bit instruction word from instruction memory over a req/ack handshake.
- Presents `inst` and a one-cycle `enable` pulse to the core, so the core executes exactly one instruction per fetch.
- Provides an ack-timeout fault and a 16-bit retired-instruction counter.

---
 rtl/smachine_pkg.sv | 27 ++
 rtl/fetch_timeout_ctr.sv | 37 +++
 rtl/inst_fetch_unit.sv | 141 ++++++++++++++
 tb/tb_inst_fetch_unit.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/smachine_pkg.sv
// Shared S-Machine definitions: bus widths, fetch FSM states and the
// instruction field layout used by both the fetch stage and the core.
package smachine_pkg;

    localparam int ADDR_W = 8;
    localparam int INST_W = 16;

    // Instruction fields: [15:12] opcode, [11:8] register, [7:0] immediate/target
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int REG_MSB = 11;
    localparam int REG_LSB = 8;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        ISSUE = 2'd2,
        FAULT = 2'd3
    } fetch_state_t;

    function automatic logic [OPC_MSB-OPC_LSB:0] opcode_of(input logic [INST_W-1:0] word);
        return word[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/fetch_timeout_ctr.sv
// Wait-cycle timer for the fetch stage: synchronous clear, increment, and a
// terminal-count flag raised when the count reaches TIMEOUT-1.
module fetch_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic tc
);

    localparam logic [7:0] TC_VAL = 8'(TIMEOUT - 1);

    logic [7:0] count_q;
    logic [7:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = 8'd0;
        end else if (inc) begin
            count_d = count_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == TC_VAL);

endmodule

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage for the S-Machine core: fetches one word per PC over
// req/ack and strobes it into the core. Optional step gating: INST_FETCH_STEP_EN.
module inst_fetch_unit #(
    parameter int ADDR_W  = smachine_pkg::ADDR_W,
    parameter int INST_W  = smachine_pkg::INST_W,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
`ifdef INST_FETCH_STEP_EN
    input  logic              step,
`endif
    input  logic              run,
    input  logic [ADDR_W-1:0] pc,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [INST_W-1:0] imem_data,
    output logic [INST_W-1:0] inst,
    output logic              enable,
    output logic              fault,
    output logic [15:0]       retired
);

    import smachine_pkg::*;

    fetch_state_t      state_q, state_d;
    logic              imem_req_q, imem_req_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [INST_W-1:0] inst_q, inst_d;
    logic              enable_q, enable_d;
    logic              fault_q, fault_d;
    logic [15:0]       retired_q, retired_d;
    logic              tmr_clr, tmr_inc, tmr_tc;
    logic              start_fetch;

`ifdef INST_FETCH_STEP_EN
    // Edges arriving outside IDLE are lost because the edge lasts one cycle.
    logic step_q, step_d;

    always_comb step_d = step;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step_d;
        end
    end

    always_comb start_fetch = run & step & ~step_q;
`else
    always_comb start_fetch = run;
`endif

    fetch_timeout_ctr #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk (clk),
        .rst (rst),
        .clr (tmr_clr),
        .inc (tmr_inc),
        .tc  (tmr_tc)
    );

    always_comb begin
        state_d     = state_q;
        imem_req_d  = imem_req_q;
        imem_addr_d = imem_addr_q;
        inst_d      = inst_q;
        enable_d    = 1'b0;
        fault_d     = fault_q;
        retired_d   = retired_q;
        tmr_clr     = 1'b0;
        tmr_inc     = 1'b0;

        case (state_q)
            IDLE: begin
                if (start_fetch) begin
                    imem_addr_d = pc;
                    imem_req_d  = 1'b1;
                    tmr_clr     = 1'b1;
                    state_d     = WAIT;
                end
            end
            WAIT: begin
                // An ack on the last permitted cycle still completes the fetch.
                if (imem_ack) begin
                    inst_d     = imem_data;
                    imem_req_d = 1'b0;
                    enable_d   = 1'b1;
                    state_d    = ISSUE;
                end else if (tmr_tc) begin
                    imem_req_d = 1'b0;
                    fault_d    = 1'b1;
                    state_d    = FAULT;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            ISSUE: begin
                retired_d = retired_q + 16'd1;
                state_d   = IDLE;
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            imem_req_q  <= 1'b0;
            imem_addr_q <= '0;
            inst_q      <= '0;
            enable_q    <= 1'b0;
            fault_q     <= 1'b0;
            retired_q   <= 16'd0;
        end else begin
            state_q     <= state_d;
            imem_req_q  <= imem_req_d;
            imem_addr_q <= imem_addr_d;
            inst_q      <= inst_d;
            enable_q    <= enable_d;
            fault_q     <= fault_d;
            retired_q   <= retired_d;
        end
    end

    assign imem_req  = imem_req_q;
    assign imem_addr = imem_addr_q;
    assign inst      = inst_q;
    assign enable    = enable_q;
    assign fault     = fault_q;
    assign retired   = retired_q;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Directed bench for inst_fetch_unit: issued fetches are queued as expected
// {addr, inst} pairs and popped by a monitor on every enable pulse.
module tb_inst_fetch_unit;

    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        run;
    logic [7:0]  pc;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic [15:0] inst;
    logic        enable;
    logic        fault;
    logic [15:0] retired;
    logic        step;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [23:0] exp_q[$];
    logic [15:0] exp_retired;
    logic        prev_en = 1'b0;
    logic [23:0] exp_item;

    always #5 clk = ~clk;

    inst_fetch_unit #(
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
`ifdef INST_FETCH_STEP_EN
        .step      (step),
`endif
        .run       (run),
        .pc        (pc),
        .imem_req  (imem_req),
        .imem_addr (imem_addr),
        .imem_ack  (imem_ack),
        .imem_data (imem_data),
        .inst      (inst),
        .enable    (enable),
        .fault     (fault),
        .retired   (retired)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every enable pulse must match the oldest outstanding fetch.
    initial begin
        forever begin
            @(negedge clk);
            if (enable) begin
                check("enable_single_cycle", {31'd0, prev_en}, 32'd0);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_enable: got enable=1 with inst %0h, expected no issue", inst);
                end else begin
                    exp_item = exp_q.pop_front();
                    check("issue_addr_inst", {8'd0, imem_addr, inst}, {8'd0, exp_item});
                end
            end
            prev_en = enable;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog");
    end

    task automatic wait_req(output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!imem_req && n < 20);
    endtask

    // One complete fetch; returns at the following IDLE cycle with run low.
    task automatic fetch(input logic [7:0] pc_v, input logic [15:0] data_v, input int lat,
                         input bit chg_pc, input bit drop_run);
        int n;
        pc   = pc_v;
        run  = 1'b1;
        step = 1'b1;
        exp_q.push_back({pc_v, data_v});
        wait_req(n);
        step = 1'b0;
        check("req_latency", n, 1);
        check("fetch_addr", {24'd0, imem_addr}, {24'd0, pc_v});
        for (int i = 1; i < lat; i++) begin
            if (chg_pc) pc = pc_v + 8'(i * 3);
            if (drop_run) run = 1'b0;
            @(negedge clk);
            check("req_held", {31'd0, imem_req}, 32'd1);
            check("addr_held", {24'd0, imem_addr}, {24'd0, pc_v});
        end
        if (drop_run) run = 1'b0;
        imem_ack  = 1'b1;
        imem_data = data_v;
        @(negedge clk);
        imem_ack  = 1'b0;
        imem_data = 16'hDEAD;
        run       = 1'b0;
        check("issue_enable", {31'd0, enable}, 32'd1);
        check("issue_req_low", {31'd0, imem_req}, 32'd0);
        exp_retired = exp_retired + 16'd1;
        @(negedge clk);
        check("post_enable_low", {31'd0, enable}, 32'd0);
        check("post_retired", {16'd0, retired}, {16'd0, exp_retired});
        check("post_inst_held", {16'd0, inst}, {16'd0, data_v});
        check("post_no_fault", {31'd0, fault}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_req"}, {31'd0, imem_req}, 32'd0);
        check({tag, "_addr"}, {24'd0, imem_addr}, 32'd0);
        check({tag, "_inst"}, {16'd0, inst}, 32'd0);
        check({tag, "_enable"}, {31'd0, enable}, 32'd0);
        check({tag, "_fault"}, {31'd0, fault}, 32'd0);
        check({tag, "_retired"}, {16'd0, retired}, 32'd0);
    endtask

    initial begin
        int n;
        rst         = 1'b1;
        run         = 1'b0;
        pc          = 8'h00;
        imem_ack    = 1'b0;
        imem_data   = 16'h0000;
        step        = 1'b0;
        exp_retired = 16'd0;

        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Single fetch acked in the first WAIT cycle
        fetch(8'h05, 16'h2A03, 1, 1'b0, 1'b0);

        // Ack latency of 4 with PC moving underneath
        fetch(8'h12, 16'h7C41, 4, 1'b1, 1'b0);

        // run dropped while waiting: the fetch still issues exactly once
        fetch(8'h20, 16'h1234, 3, 1'b0, 1'b1);
        repeat (5) begin
            @(negedge clk);
            check("parked_req_low", {31'd0, imem_req}, 32'd0);
        end

        // No ack: fault after TIMEOUT WAIT cycles
        pc   = 8'h33;
        run  = 1'b1;
        step = 1'b1;
        wait_req(n);
        step = 1'b0;
        check("to_req_latency", n, 1);
        n = 0;
        while (imem_req && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("to_wait_cycles", n, TIMEOUT);
        check("to_fault", {31'd0, fault}, 32'd1);
        check("to_inst_held", {16'd0, inst}, 32'h1234);
        check("to_retired", {16'd0, retired}, {16'd0, exp_retired});
        repeat (4) begin
            pc = pc + 8'd1;
            @(negedge clk);
            check("fault_sticky", {31'd0, fault}, 32'd1);
            check("fault_req_low", {31'd0, imem_req}, 32'd0);
        end
        run = 1'b0;
        rst = 1'b1;
        #1;
        check_all_zero("fault_rst");
        @(negedge clk);
        rst = 1'b0;
        exp_retired = 16'd0;
        @(negedge clk);

        // Reset mid-WAIT, then a late ack
        pc   = 8'h40;
        run  = 1'b1;
        step = 1'b1;
        wait_req(n);
        step = 1'b0;
        check("rw_req_up", {31'd0, imem_req}, 32'd1);
        rst = 1'b1;
        run = 1'b0;
        #1;
        check("rw_async_req_drop", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        rst       = 1'b0;
        imem_ack  = 1'b1;
        imem_data = 16'hBEEF;
        @(negedge clk);
        imem_ack  = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check_all_zero("late_ack");
        end

        // Retired counter wrap
        force dut.retired_q = 16'hFFFF;
        @(negedge clk);
        release dut.retired_q;
        @(negedge clk);
        check("preload_retired", {16'd0, retired}, 32'h0000FFFF);
        exp_retired = 16'hFFFF;
        fetch(8'h7F, 16'hABCD, 2, 1'b0, 1'b0);
        check("wrap_retired", {16'd0, retired}, 32'd0);

`ifdef INST_FETCH_STEP_EN
        // Three step edges give exactly three issues; run alone starts nothing
        fetch(8'h01, 16'h1111, 1, 1'b0, 1'b0);
        fetch(8'h02, 16'h2222, 2, 1'b0, 1'b0);
        fetch(8'h03, 16'h3333, 1, 1'b0, 1'b0);
        check("step_retired", {16'd0, retired}, 32'd3);
        run  = 1'b1;
        step = 1'b1;
        repeat (2) @(negedge clk);
        imem_ack  = 1'b1;
        imem_data = 16'h4444;
        exp_q.push_back({8'h03, 16'h4444});
        @(negedge clk);
        imem_ack = 1'b0;
        repeat (6) begin
            @(negedge clk);
            check("step_held_no_refetch", {31'd0, imem_req}, 32'd0);
        end
        run  = 1'b0;
        step = 1'b0;
`else
        // Free-running: with ack always high, an issue every 3 cycles
        pc        = 8'h50;
        imem_data = 16'h5A5A;
        imem_ack  = 1'b1;
        run       = 1'b1;
        for (int k = 0; k < 3; k++) exp_q.push_back({8'h50, 16'h5A5A});
        n = 0;
        repeat (9) begin
            @(negedge clk);
            if (enable) n++;
        end
        run = 1'b0;
        check("free_run_issues", n, 3);
        repeat (3) @(negedge clk);
        imem_ack = 1'b0;
        check("free_run_retired", {16'd0, retired}, 32'd3);
`endif

        repeat (3) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
